// File: rtl/bus_endpoint_fifo_if.sv
// ---------------------------------------------------------------------------
// bus_endpoint_fifo_if
// Purpose : groups the bus-port signals (pndng/pop/D_pop, push/D_push) and the
//           local TX/RX handshakes of one bus endpoint into a single bundle.
// Modports: slave  - the endpoint (drives pndng, D_pop, tx_ready, rx_valid,
//                    rx_data, counts, rx_overflow)
//           master - bus controller plus local logic (drives pop, push, D_push,
//                    tx_valid, tx_data, rx_ready, ovf_clr)
// Parameters: pckg_sz (packet width), depth (entries per FIFO)
// ---------------------------------------------------------------------------
interface bus_endpoint_fifo_if #(
   parameter int pckg_sz = 16,
   parameter int depth   = 8
);
   localparam int CW = $clog2(depth) + 1;

   logic               pndng;
   logic [pckg_sz-1:0] D_pop;
   logic               pop;
   logic               push;
   logic [pckg_sz-1:0] D_push;
   logic               tx_valid;
   logic [pckg_sz-1:0] tx_data;
   logic               tx_ready;
   logic               rx_valid;
   logic [pckg_sz-1:0] rx_data;
   logic               rx_ready;
   logic [CW-1:0]      tx_count;
   logic [CW-1:0]      rx_count;
   logic               rx_overflow;
   logic               ovf_clr;

   modport slave (
      output pndng, D_pop, tx_ready, rx_valid, rx_data, tx_count, rx_count, rx_overflow,
      input  pop, push, D_push, tx_valid, tx_data, rx_ready, ovf_clr
   );

   modport master (
      input  pndng, D_pop, tx_ready, rx_valid, rx_data, tx_count, rx_count, rx_overflow,
      output pop, push, D_push, tx_valid, tx_data, rx_ready, ovf_clr
   );
endinterface

// File: rtl/bus_endpoint_fifo.sv
// ---------------------------------------------------------------------------
// bus_endpoint_fifo
// Purpose : device-side endpoint of one bus port. TX FIFO is written by local
//           logic and popped by the bus controller; RX FIFO is pushed by the
//           bus controller and drained by local logic. Both FIFOs are
//           first-word fall-through with registered head/flag outputs.
// Ports   : clk   - single clock, rising edge
//           reset - asynchronous, active-low
//           bus   - bus_endpoint_fifo_if.slave (all handshake/data signals)
// Parameters: pckg_sz (packet width, dest ID in top 8 bits), depth (power of 2,
//           >=2), drv_id (this endpoint's ID, used by the address filter)
// Build option: BUS_EP_ADDR_FILTER_EN - when defined, inbound packets whose
//           destination ID differs from drv_id are dropped silently.
// ---------------------------------------------------------------------------
module bus_endpoint_fifo #(
   parameter int         pckg_sz = 16,
   parameter int         depth   = 8,
   parameter logic [7:0] drv_id  = 8'd0
) (
   input logic                clk,
   input logic                reset,
   bus_endpoint_fifo_if.slave bus
);
   localparam int            AW   = $clog2(depth);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(depth);

   // ---------------- TX path ----------------
   logic [pckg_sz-1:0] tx_mem [depth];
   logic [AW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
   logic [pckg_sz-1:0] tx_head_q, tx_head_d;
   logic               tx_pndng_q, tx_rdy_q;
   logic               tx_we, tx_re;

   always_comb begin
      tx_we     = bus.tx_valid && tx_rdy_q;
      tx_re     = bus.pop && tx_pndng_q;
      tx_wr_d   = tx_we ? tx_wr_q + AW'(1) : tx_wr_q;
      tx_rd_d   = tx_re ? tx_rd_q + AW'(1) : tx_rd_q;
      tx_cnt_d  = tx_cnt_q;
      tx_head_d = tx_head_q;
      case ({tx_we, tx_re})
         2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
      // Next head: bypass the write data when it lands exactly at the new read
      // pointer (write into empty, or pop+write with one entry left).
      if (tx_cnt_d != '0) begin
         if (tx_we && (tx_wr_q == tx_rd_d)) tx_head_d = bus.tx_data;
         else                               tx_head_d = tx_mem[tx_rd_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset && tx_we) tx_mem[tx_wr_q] <= bus.tx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         tx_cnt_q   <= '0;
         tx_head_q  <= '0;
         tx_pndng_q <= 1'b0;
         tx_rdy_q   <= 1'b1;
      end else begin
         tx_wr_q    <= tx_wr_d;
         tx_rd_q    <= tx_rd_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_head_q  <= tx_head_d;
         tx_pndng_q <= (tx_cnt_d != '0);
         tx_rdy_q   <= (tx_cnt_d != FULL);
      end
   end

   // ---------------- RX path ----------------
   logic [pckg_sz-1:0] rx_mem [depth];
   logic [AW-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
   logic [pckg_sz-1:0] rx_head_q, rx_head_d;
   logic               rx_valid_q, rx_ovf_q, rx_ovf_d;
   logic               rx_addr_ok, rx_we, rx_re, rx_ovf_set;

`ifdef BUS_EP_ADDR_FILTER_EN
   assign rx_addr_ok = (bus.D_push[pckg_sz-1 -: 8] == drv_id);
`else
   logic [7:0] unused_drv_id;
   assign unused_drv_id = drv_id;
   assign rx_addr_ok    = 1'b1;
`endif

   always_comb begin
      rx_re      = bus.rx_ready && rx_valid_q;
      // A full FIFO still accepts a push when a read frees a slot at the same edge.
      rx_we      = bus.push && rx_addr_ok && ((rx_cnt_q != FULL) || rx_re);
      rx_ovf_set = bus.push && rx_addr_ok && !rx_we;
      rx_wr_d    = rx_we ? rx_wr_q + AW'(1) : rx_wr_q;
      rx_rd_d    = rx_re ? rx_rd_q + AW'(1) : rx_rd_q;
      rx_cnt_d   = rx_cnt_q;
      rx_head_d  = rx_head_q;
      case ({rx_we, rx_re})
         2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase
      if (rx_cnt_d != '0) begin
         if (rx_we && (rx_wr_q == rx_rd_d)) rx_head_d = bus.D_push;
         else                               rx_head_d = rx_mem[rx_rd_d];
      end
      // Set has priority over clear so a same-cycle drop is never lost.
      if (rx_ovf_set)       rx_ovf_d = 1'b1;
      else if (bus.ovf_clr) rx_ovf_d = 1'b0;
      else                  rx_ovf_d = rx_ovf_q;
   end

   always_ff @(posedge clk) begin
      if (reset && rx_we) rx_mem[rx_wr_q] <= bus.D_push;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         rx_cnt_q   <= '0;
         rx_head_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovf_q   <= 1'b0;
      end else begin
         rx_wr_q    <= rx_wr_d;
         rx_rd_q    <= rx_rd_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_head_q  <= rx_head_d;
         rx_valid_q <= (rx_cnt_d != '0);
         rx_ovf_q   <= rx_ovf_d;
      end
   end

   // ---------------- outputs (registers only) ----------------
   assign bus.pndng       = tx_pndng_q;
   assign bus.D_pop       = tx_head_q;
   assign bus.tx_ready    = tx_rdy_q;
   assign bus.tx_count    = tx_cnt_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.rx_data     = rx_head_q;
   assign bus.rx_count    = rx_cnt_q;
   assign bus.rx_overflow = rx_ovf_q;

endmodule
